// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: in-order instruction fetch with credit-limited buffer, branch stall and redirect flush
module fetch_issue_unit #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 16,
  parameter int DEPTH    = 2,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [3:0]         if_op,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               branch_nt,
  output logic               fetch_busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [3:0] OP_BR = 4'b1100;
  typedef enum logic {RUN, BR_WAIT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0] outstanding, occupancy, discard;
  logic [CW+1:0] used;
  logic [PW-1:0] rd_ptr, wr_ptr, pq_rd, pq_wr;
  logic [INSTR_W-1:0] buf_instr [DEPTH];
  logic [ADDR_W-1:0] buf_pc [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic accept, take, wr, pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // every issued request, buffered word and word still to drop holds one credit
  assign used = (CW+2)'(outstanding) + (CW+2)'(occupancy) + (CW+2)'(discard);
  assign imem_req_valid = !rst && state == RUN && used < (CW+2)'(DEPTH) && !redirect_valid;
  assign imem_addr = pc;
  assign accept = imem_req_valid && imem_req_ready;
  assign take = imem_rsp_valid && discard == '0;
  assign wr = take && !redirect_valid;
  assign if_valid = occupancy != '0;
  assign pop = if_valid && if_ready;
  assign if_instr = buf_instr[rd_ptr];
  assign if_op = if_instr[INSTR_W-1 -: 4];
  assign if_pc = buf_pc[rd_ptr];
  assign fetch_busy = outstanding != '0 || discard != '0;

  always_comb
    state_n = redirect_valid ? RUN :
              (state == RUN && wr && imem_rsp_data[INSTR_W-1 -: 4] == OP_BR) ? BR_WAIT :
              (state == BR_WAIT && branch_nt) ? RUN : state;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else state <= state_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= ADDR_W'(RESET_PC);
      outstanding <= '0;
      occupancy <= '0;
      discard <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      pq_rd <= '0;
      pq_wr <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      outstanding <= '0;
      occupancy <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      pq_rd <= '0;
      pq_wr <= '0;
      discard <= discard + outstanding - CW'(imem_rsp_valid);
    end else begin
      if (accept) begin
        pc <= pc + ADDR_W'(PC_STEP);
        pq_wr <= inc(pq_wr);
      end
      if (take) pq_rd <= inc(pq_rd);
      if (wr) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      outstanding <= outstanding + CW'(accept) - CW'(take);
      occupancy <= occupancy + CW'(wr) - CW'(pop);
      discard <= discard - CW'(imem_rsp_valid && discard != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pc_q[pq_wr] <= pc;
    if (wr) begin
      buf_instr[wr_ptr] <= imem_rsp_data;
      buf_pc[wr_ptr] <= pc_q[pq_rd];
    end
  end
endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb_fetch_issue_unit: randomized scoreboard bench; expected decode stream is the sequential address stream restarted by redirects
module tb_fetch_issue_unit;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready = 0;
  logic [15:0] imem_addr;
  logic imem_rsp_valid = 0;
  logic [15:0] imem_rsp_data = 0;
  logic if_valid, if_ready = 0;
  logic [15:0] if_instr, if_pc;
  logic [3:0] if_op;
  logic redirect_valid = 0, branch_nt = 0;
  logic [15:0] redirect_pc = 0;
  logic fetch_busy;

  fetch_issue_unit dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_op(if_op), .if_pc(if_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .branch_nt(branch_nt),
    .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] pc; logic [15:0] instr; } exp_t;
  typedef struct { logic [15:0] addr; int due; } req_t;
  exp_t exp_q[$];
  req_t mem_q[$];
  exp_t mon_e;
  int checks = 0, failures = 0, cyc = 0, acc_cnt = 0;
  int br_pops = 0, br_handled = 0, br_wait = 0;
  logic [15:0] nf = 0;
  bit clean = 1, watch = 0;
  int p_mrdy, p_rsp, max_lat, p_ifr, p_redir, br_mode;
  logic [15:0] br_pc = 0, force_pc = 0;
  bit force_v = 0;

  // instruction memory contents: fixed words at the start, a mixing hash elsewhere
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h0123;
      16'h0004: return 16'h1415;
      16'h0008: return 16'h3614;
      16'h000C: return 16'hC00C;
      default:  return {a[5:2] ^ a[9:6] ^ a[13:10], a[11:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic knobs(input int mr, input int rs, input int lat, input int ifr, input int redir, input int mode);
    p_mrdy = mr; p_rsp = rs; max_lat = lat; p_ifr = ifr; p_redir = redir; br_mode = mode;
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      chk("fetch_busy", fetch_busy, mem_q.size() != 0);
      if (watch) chk("no_req_in_br_wait", imem_req_valid, 0);
      if (imem_req_valid && imem_req_ready) chk("imem_addr", imem_addr, nf);
      if (if_valid && if_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop actual_pc=%0h required=none at %0t", if_pc, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("if_pc", if_pc, mon_e.pc);
          chk("if_instr", if_instr, mon_e.instr);
          chk("if_op", if_op, mon_e.instr[15:12]);
          if (mon_e.instr[15:12] == 4'b1100) begin
            br_pops++;
            if (clean) begin watch = 1; clean = 0; end
          end
        end
      end
      if (redirect_valid) begin clean = 1; watch = 0; end
      else if (branch_nt) watch = 0;
    end else begin
      clean = 1;
      watch = 0;
    end
  end

  task automatic cycle();
    @(negedge clk);
    cyc++;
    imem_req_ready = ($urandom % 100) < p_mrdy;
    if_ready = ($urandom % 100) < p_ifr;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc && ($urandom % 100) < p_rsp) begin
      imem_rsp_valid = 1;
      imem_rsp_data = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_data = 16'($urandom);
    end
    redirect_valid = 0;
    branch_nt = 0;
    redirect_pc = 16'($urandom);
    if (force_v) begin
      redirect_valid = 1;
      redirect_pc = force_pc;
      force_v = 0;
    end else if (br_pops != br_handled) begin
      if (br_wait > 0) br_wait--;
      else begin
        br_handled = br_pops;
        br_wait = int'($urandom % 4);
        if (br_mode == 1 || (br_mode == 0 && ($urandom % 2) == 0)) branch_nt = 1;
        else begin
          redirect_valid = 1;
          redirect_pc = br_mode == 2 ? br_pc : 16'($urandom) & 16'hFFFC;
          branch_nt = 1'($urandom);
        end
      end
    end else if (($urandom % 1000) < p_redir) begin
      redirect_valid = 1;
      redirect_pc = 16'($urandom) & 16'hFFFC;
    end
    #2;
    if (imem_req_valid && imem_req_ready) begin
      exp_q.push_back('{nf, mem_word(nf)});
      mem_q.push_back('{imem_addr, cyc + 1 + int'($urandom % max_lat)});
      nf += 16'd4;
      acc_cnt++;
    end
    if (imem_rsp_valid) void'(mem_q.pop_front());
    if (redirect_valid) begin
      exp_q.delete();
      nf = redirect_pc;
      br_handled = br_pops;
    end
  endtask

  task automatic do_reset();
    rst = 1;
    imem_req_ready = 0;
    if_ready = 0;
    imem_rsp_valid = 0;
    redirect_valid = 0;
    branch_nt = 0;
    #1;
    chk("rst_if_valid", if_valid, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_fetch_busy", fetch_busy, 0);
    mem_q.delete();
    exp_q.delete();
    nf = 16'h0;
    br_handled = br_pops;
    br_wait = 0;
    force_v = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    knobs(100, 100, 1, 100, 0, 1);
    do_reset();
    repeat (25) cycle();
    do_reset();
    knobs(100, 100, 1, 0, 0, 1);
    acc_cnt = 0;
    repeat (10) cycle();
    chk("stall_accepts", acc_cnt, 2);
    chk("stall_req_valid", imem_req_valid, 0);
    p_ifr = 100;
    repeat (20) cycle();
    do_reset();
    knobs(100, 100, 3, 100, 0, 2);
    br_pc = 16'h0040;
    repeat (30) cycle();
    knobs(100, 100, 1, 100, 0, 1);
    force_pc = 16'hFFF8;
    force_v = 1;
    repeat (20) cycle();
    knobs(70, 70, 4, 60, 5, 0);
    repeat (4000) cycle();
    knobs(100, 100, 1, 0, 0, 1);
    force_pc = 16'h0100;
    force_v = 1;
    repeat (8) cycle();
    chk("prereset_if_valid", if_valid, 1);
    #1;
    do_reset();
    knobs(100, 100, 1, 100, 0, 1);
    repeat (20) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
